// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver with a valid/read byte handshake.
//
// Recovers frames (start bit, DATA_BITS data bits LSB first, one stop bit)
// from an asynchronous serial line. Each bit is sampled at its midpoint, which
// is found once from the start bit and then held for the rest of the frame.
// Framing errors and overruns are reported as sticky flags.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_rx_en      enables start-bit detection (does not abort a frame)
//   i_rx_in      asynchronous serial line, idle high
//   i_read       consumer acknowledge, honoured only while o_valid=1
//   o_rx_out     last received byte
//   o_valid      o_rx_out holds an unread byte
//   o_frame_err  last frame had stop bit = 0 (sticky until next good frame)
//   o_overrun    a byte was overwritten before being read (sticky until read)
//   o_busy       frame reception in progress
//
// CLKS_PER_BIT must be an even number >= 4. DATA_BITS is fixed at 8.
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx_en,
    input  logic                 i_rx_in,
    input  logic                 i_read,
    output logic [DATA_BITS-1:0] o_rx_out,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = 3;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    // Registers
    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_out;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;
    logic                 r_busy;

    // Next-state values
    logic                 w_srx;
    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_rx_out_nxt;
    logic                 w_valid_nxt;
    logic                 w_frame_err_nxt;
    logic                 w_overrun_nxt;
    logic                 w_busy_nxt;

    // Two-flop synchronizer; resets to the idle-high line level
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_srx = r_sync2;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_rx_out    <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_out    <= w_rx_out_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state, datapath and handshake logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_idx_nxt       = r_idx;
        w_shift_nxt     = r_shift;
        w_rx_out_nxt    = r_rx_out;
        w_valid_nxt     = r_valid;
        w_frame_err_nxt = r_frame_err;
        w_overrun_nxt   = r_overrun;

        // Consumer read; a byte completing in the same cycle overrides valid below
        if (r_valid && i_read) begin
            w_valid_nxt   = 1'b0;
            w_overrun_nxt = 1'b0;
        end

        unique case (r_state)
            S_IDLE: begin
                if (i_rx_en && !w_srx) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end

            // Confirm the start bit at its midpoint; a high line here is a glitch
            S_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt = '0;
                    if (!w_srx) begin
                        w_state_nxt = S_DATA;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            // Shift right so the first (LSB) bit ends up in bit 0
            S_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_srx, r_shift[DATA_BITS-1:1]};
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_srx) begin
                        w_rx_out_nxt    = r_shift;
                        w_valid_nxt     = 1'b1;
                        w_frame_err_nxt = 1'b0;
                        if (r_valid && !i_read) begin
                            w_overrun_nxt = 1'b1;
                        end
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = S_BREAK;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            // Hold off until the line returns high so a stuck-low line cannot retrigger
            S_BREAK: begin
                if (w_srx) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign o_rx_out    = r_rx_out;
    assign o_valid     = r_valid;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

endmodule
